// File: rtl/fifo_drain_pkg.sv
// Shared types for the fifo_flops drain stage and its statistics block.
// Optional statistics are enabled with the FIFO_DRAIN_STATS_EN macro.
package fifo_drain_pkg;

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_TWO   = 2'd2
  } occ_e;

  localparam int DRAIN_CNT_W_DEF = 16;

endpackage

// File: rtl/fifo_drain_stats.sv
// Saturating transfer/stall counters for fifo_drain_skid.
// Instantiated only when FIFO_DRAIN_STATS_EN is defined.
module fifo_drain_stats
  import fifo_drain_pkg::*;
#(
  parameter int CNT_W = DRAIN_CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             xfer,
  input  logic             stall,
  output logic [CNT_W-1:0] xfer_count,
  output logic [CNT_W-1:0] stall_count
);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
    if (en && (v != {CNT_W{1'b1}})) begin
      return v + CNT_W'(1'b1);
    end else begin
      return v;
    end
  endfunction

  logic [CNT_W-1:0] xfer_count_r;
  logic [CNT_W-1:0] stall_count_r;

  // Counter registers; both stick at all-ones instead of wrapping.
  always_ff @(posedge clk) begin
    if (rst) begin
      xfer_count_r  <= {CNT_W{1'b0}};
      stall_count_r <= {CNT_W{1'b0}};
    end else begin
      xfer_count_r  <= sat_inc(xfer_count_r, xfer);
      stall_count_r <= sat_inc(stall_count_r, stall);
    end
  end

  assign xfer_count  = xfer_count_r;
  assign stall_count = stall_count_r;

endmodule

// File: rtl/fifo_drain_skid.sv
// Drains fifo_flops into a 2-entry skid buffer with a registered valid/ready output.
// Define FIFO_DRAIN_STATS_EN to add the CNT_W parameter and the xfer/stall counters.
module fifo_drain_skid
  import fifo_drain_pkg::*;
#(
  parameter int bits = 16
`ifdef FIFO_DRAIN_STATS_EN
  ,
  parameter int CNT_W = DRAIN_CNT_W_DEF
`endif
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [bits-1:0]  fifo_dout,
  input  logic             fifo_pndng,
  output logic             fifo_pop,
  output logic [bits-1:0]  out_data,
  output logic             out_valid,
  input  logic             out_ready
`ifdef FIFO_DRAIN_STATS_EN
  ,
  output logic [CNT_W-1:0] xfer_count,
  output logic [CNT_W-1:0] stall_count
`endif
);

  occ_e            occ_r;
  logic [bits-1:0] main_r;
  logic [bits-1:0] skid_r;
  logic            valid_r;
  logic            pop_s;
  logic            fire_s;

  // Pop depends only on state and pndng, so out_ready never reaches fifo_pop.
  assign pop_s  = fifo_pndng & (occ_r != OCC_TWO) & ~rst;
  assign fire_s = valid_r & out_ready;

  // Occupancy FSM; main_r always holds the oldest buffered word.
  always_ff @(posedge clk) begin
    if (rst) begin
      occ_r   <= OCC_EMPTY;
      main_r  <= {bits{1'b0}};
      skid_r  <= {bits{1'b0}};
      valid_r <= 1'b0;
    end else begin
      case (occ_r)
        OCC_EMPTY: begin
          if (pop_s) begin
            main_r  <= fifo_dout;
            occ_r   <= OCC_ONE;
            valid_r <= 1'b1;
          end
        end
        OCC_ONE: begin
          if (pop_s && fire_s) begin
            main_r <= fifo_dout;
          end else if (pop_s) begin
            skid_r <= fifo_dout;
            occ_r  <= OCC_TWO;
          end else if (fire_s) begin
            occ_r   <= OCC_EMPTY;
            valid_r <= 1'b0;
          end
        end
        OCC_TWO: begin
          if (fire_s) begin
            main_r <= skid_r;
            occ_r  <= OCC_ONE;
          end
        end
        default: begin
          occ_r   <= OCC_EMPTY;
          valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign fifo_pop  = pop_s;
  assign out_data  = main_r;
  assign out_valid = valid_r;

`ifdef FIFO_DRAIN_STATS_EN
  fifo_drain_stats #(
    .CNT_W(CNT_W)
  ) u_stats (
    .clk        (clk),
    .rst        (rst),
    .xfer       (fire_s),
    .stall      (valid_r & ~out_ready),
    .xfer_count (xfer_count),
    .stall_count(stall_count)
  );
`endif

endmodule

// File: tb/tb_fifo_drain_skid.sv
// Scoreboard bench for fifo_drain_skid with a ring-buffer model of fifo_flops.
// Counter checks run only when FIFO_DRAIN_STATS_EN is defined.
module tb_fifo_drain_skid;
  import fifo_drain_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] fifo_dout;
  logic        fifo_pndng;
  logic        fifo_pop;
  logic [15:0] out_data;
  logic        out_valid;
  logic        out_ready = 1'b0;
`ifdef FIFO_DRAIN_STATS_EN
  logic [3:0]  xfer_count;
  logic [3:0]  stall_count;
`endif

  logic [15:0] mem [0:255];
  logic [7:0]  wr_ptr = 8'd0;
  logic [7:0]  rd_ptr = 8'd0;
  logic [15:0] exp_q [$];
  int          n_tests = 0;
  int          n_fail  = 0;
  logic        prev_stall = 1'b0;
  logic [15:0] prev_data = 16'd0;

  fifo_drain_skid #(
    .bits(16)
`ifdef FIFO_DRAIN_STATS_EN
    ,
    .CNT_W(4)
`endif
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .fifo_dout  (fifo_dout),
    .fifo_pndng (fifo_pndng),
    .fifo_pop   (fifo_pop),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready)
`ifdef FIFO_DRAIN_STATS_EN
    ,
    .xfer_count (xfer_count),
    .stall_count(stall_count)
`endif
  );

  always #5 clk = ~clk;

  assign fifo_dout  = mem[rd_ptr];
  assign fifo_pndng = (wr_ptr != rd_ptr);

  // FIFO model: the head leaves at the edge where fifo_pop is high.
  always @(posedge clk) begin
    if (fifo_pop) rd_ptr <= rd_ptr + 8'd1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [15:0] w);
    mem[wr_ptr] = w;
    wr_ptr = wr_ptr + 8'd1;
    exp_q.push_back(w);
  endtask

  task automatic wait_drain(input int bound);
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !out_valid) return;
    end
    n_tests++;
    n_fail++;
    $display("FAIL drain_timeout: %0d words still expected after %0d cycles", exp_q.size(), bound);
  endtask

  // Monitor: scoreboard on every transfer, hold-stability and pop legality.
  always @(negedge clk) begin
    if (!rst) begin
      if (fifo_pop) check("pop_needs_pndng", 32'(fifo_pndng), 32'd1);
      if (prev_stall && out_valid) check("hold_stable", 32'(out_data), 32'(prev_data));
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL sb_extra: got %0h expected no word", out_data);
        end else begin
          check("sb_data", 32'(out_data), 32'(exp_q.pop_front()));
        end
      end
      prev_stall <= out_valid && !out_ready;
      prev_data  <= out_data;
    end else begin
      prev_stall <= 1'b0;
    end
  end

  initial begin
    int pops;
    for (int i = 0; i < 256; i++) mem[i] = 16'd0;

    // 1: reset with a word pending in the FIFO
    push(16'hBEEF);
    repeat (2) begin
      @(negedge clk);
      check("rst_pop", 32'(fifo_pop), 32'd0);
      check("rst_valid", 32'(out_valid), 32'd0);
      check("rst_data", 32'(out_data), 32'd0);
`ifdef FIFO_DRAIN_STATS_EN
      check("rst_xfer", 32'(xfer_count), 32'd0);
      check("rst_stall", 32'(stall_count), 32'd0);
`endif
    end
    @(posedge clk); #1;
    rst = 1'b0;
    out_ready = 1'b1;
    wait_drain(20);

    // 2: streaming 1..8 with out_ready held high
    @(posedge clk); #1;
    for (int i = 1; i <= 8; i++) push(16'(i));
    @(negedge clk);
    check("s_first_pop", 32'(fifo_pop), 32'd1);
    check("s_first_nvalid", 32'(out_valid), 32'd0);
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      check("s_valid", 32'(out_valid), 32'd1);
      check("s_data", 32'(out_data), 32'(i));
    end
    wait_drain(20);

    // 3: back-pressure fills the skid buffer
    @(posedge clk); #1;
    out_ready = 1'b0;
    push(16'hA5A5);
    push(16'h5A5A);
    push(16'h1234);
    pops = 0;
    repeat (6) begin
      @(negedge clk);
      if (fifo_pop) pops++;
    end
    check("bp_pops", 32'(pops), 32'd2);
    check("bp_state", 32'(dut.occ_r), 32'(OCC_TWO));
    check("bp_data", 32'(out_data), 32'hA5A5);
    check("bp_pndng", 32'(fifo_pndng), 32'd1);
    check("bp_no_pop", 32'(fifo_pop), 32'd0);
    @(posedge clk); #1;
    out_ready = 1'b1;
    wait_drain(20);

    // 4: 200 words with random back-pressure
    @(posedge clk); #1;
    for (int i = 0; i < 200; i++) push(16'($urandom));
    for (int c = 0; c < 3000 && (exp_q.size() != 0 || out_valid); c++) begin
      @(posedge clk); #1;
      out_ready = 1'($urandom_range(0, 1));
    end
    out_ready = 1'b1;
    wait_drain(50);

    // 5: reset while TWO with 3 words left in the FIFO
    @(posedge clk); #1;
    out_ready = 1'b0;
    push(16'h1111);
    push(16'h2222);
    push(16'h3333);
    push(16'h4444);
    push(16'h5555);
    repeat (4) @(negedge clk);
    check("r5_state", 32'(dut.occ_r), 32'(OCC_TWO));
    check("r5_fifo_level", 32'(wr_ptr - rd_ptr), 32'd3);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    check("r5_no_pop", 32'(fifo_pop), 32'd0);
    void'(exp_q.pop_front());
    void'(exp_q.pop_front());
    @(negedge clk);
    check("r5_valid", 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    out_ready = 1'b1;
    wait_drain(20);

`ifdef FIFO_DRAIN_STATS_EN
    // 6: 20 transfers and 5 stall cycles on 4-bit counters
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    out_ready = 1'b0;
    for (int i = 0; i < 20; i++) push(16'(16'h0100 + i));
    for (int i = 0; i < 10 && !out_valid; i++) @(negedge clk);
    check("st_valid", 32'(out_valid), 32'd1);
    repeat (5) @(posedge clk);
    #1;
    out_ready = 1'b1;
    wait_drain(60);
    check("st_xfer_sat", 32'(xfer_count), 32'd15);
    check("st_stall", 32'(stall_count), 32'd5);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
